elapsed_timer: RTL and testbench
================================

ELAPSED_TIMER -- requirements
Module: elapsed_timer

Interface
REQ-001 SHALL have parameter MAX_MT, default 9, meaning the highest permitted minutes-tens digit (1..9).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port tick, input, 1, one-cycle count enable (nominally 1 Hz).
REQ-005 SHALL have port start, input, 1, begin or resume counting.
REQ-006 SHALL have port stop, input, 1, pause counting.
REQ-007 SHALL have port clear, input, 1, zero all digits and return to IDLE.
REQ-008 SHALL have port load, input, 1, preset request.
REQ-009 SHALL have port load_value, input, 16, BCD preset {mt,mo,st,so}.
REQ-010 SHALL have port so, output, 4, seconds-ones digit, 0..9.
REQ-011 SHALL have port st, output, 4, seconds-tens digit, 0..5.
REQ-012 SHALL have port mo, output, 4, minutes-ones digit, 0..9.
REQ-013 SHALL have port mt, output, 4, minutes-tens digit, 0..MAX_MT.
REQ-014 SHALL have port running, output, 1, high while in RUN.
REQ-015 SHALL have port full, output, 1, high while in FULL.
REQ-016 SHALL have port min_carry, output, 1, one-cycle pulse on each st 5->0 rollover.
REQ-017 SHALL have port load_err, output, 1, one-cycle pulse on a rejected load.

Function
REQ-018 SHALL implement states IDLE, RUN, PAUSE, FULL; all outputs registered.
REQ-019 SHALL apply per-cycle control priority clear > load > stop > start > tick.
REQ-020 SHALL, on clear in any state, set all digits to 0 and go to IDLE in the next cycle.
REQ-021 SHALL accept load only in IDLE or PAUSE, and only if so<=9, st<=5, mo<=9 and mt<=MAX_MT; an accepted load writes the digits and keeps the state.
REQ-022 SHALL reject a load in RUN or FULL, or with an invalid digit: digits unchanged, load_err=1 for one cycle.
REQ-023 SHALL move IDLE->RUN and PAUSE->RUN on start; start in RUN or FULL has no effect.
REQ-024 SHALL move RUN->PAUSE on stop; stop in other states has no effect.
REQ-025 SHALL increment only in RUN with tick=1, result visible the next cycle; tick in any other state is ignored.
REQ-026 SHALL increment as follows: so 9->0 carries into st; st 5->0 carries into mo and pulses min_carry; mo 9->0 carries into mt.
REQ-027 SHALL, on a tick at mt=MAX_MT, mo=9, st=5, so=9, hold all digits, enter FULL and not pulse min_carry.
REQ-028 SHALL leave FULL only on clear or reset.
REQ-029 SHALL ignore tick when start or stop is also active in the same cycle.
REQ-030 SHALL set running=1 iff state=RUN and full=1 iff state=FULL, both updated together with the state.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, set state=IDLE, all digits=0, and running, full, min_carry, load_err=0, regardless of other inputs.
REQ-032 SHALL, on reset asserted mid-count, discard the count and any pending pulse; after release the block behaves as freshly reset.

Verification
REQ-033 SHALL cover: reset, start, 61 ticks -> 01:01, with exactly one min_carry pulse.
REQ-034 SHALL cover: load 0x0959 in IDLE, start, one tick -> 10:00, with min_carry pulse.
REQ-035 SHALL cover: MAX_MT=9, load 0x9958, start, 3 ticks -> 99:59, FULL, full=1, running=0, digits held.
REQ-036 SHALL cover: RUN at 00:05, stop, 4 ticks -> 00:05 held in PAUSE; start, 1 tick -> 00:06.
REQ-037 SHALL cover: load 0x0060 (st=6) in IDLE -> load_err pulse, digits stay 00:00; load while RUN -> load_err pulse, count continues.
REQ-038 SHALL cover: clear and tick in the same cycle at 12:34 -> 00:00, IDLE; rst=0 during RUN -> 00:00, IDLE, all flags 0.

Source files
------------

// File: rtl/elapsed_timer.sv
// elapsed_timer
//   BCD stopwatch with an mm:ss display (mt mo : st so). It advances one second per
//   tick while running. When the count reaches MAX_MT9:59 it stops there and holds.
//   A preset can be loaded while idle or paused.
//
// Parameters
//   MAX_MT      highest permitted minutes-tens digit (1..9)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-low reset
//   tick        one-cycle count enable (nominally 1 Hz)
//   start       begin or resume counting
//   stop        pause counting
//   clear       zero all digits and return to idle
//   load        preset request, accepted only in idle or pause with valid BCD digits
//   load_value  BCD preset {mt,mo,st,so}
//   so/st/mo/mt seconds-ones, seconds-tens, minutes-ones, minutes-tens digits
//   running     high while counting
//   full        high once the count has saturated at MAX_MT9:59
//   min_carry   one-cycle pulse on every seconds 59->00 rollover
//   load_err    one-cycle pulse when a load request is refused
module elapsed_timer #(
  parameter int unsigned MAX_MT = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  so,
  output logic [3:0]  st,
  output logic [3:0]  mo,
  output logic [3:0]  mt,
  output logic        running,
  output logic        full,
  output logic        min_carry,
  output logic        load_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  localparam logic [3:0] MAX_MT_D = 4'(MAX_MT);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [3:0] so_nx, st_nx, mo_nx, mt_nx;
  logic       carry_nx, err_nx;

  // A preset is acceptable only if every digit lies in its legal display range.
  function automatic logic preset_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= MAX_MT_D);
  endfunction

  // The priority is clear > load > stop > start > tick. Each branch ends the cycle's
  // decision, so a tick that arrives together with any higher-priority request is dropped.
  always_comb begin
    state_nx = state;
    so_nx    = so;
    st_nx    = st;
    mo_nx    = mo;
    mt_nx    = mt;
    carry_nx = 1'b0;
    err_nx   = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      so_nx    = 4'd0;
      st_nx    = 4'd0;
      mo_nx    = 4'd0;
      mt_nx    = 4'd0;
    end else if (load) begin
      if ((state == S_IDLE || state == S_PAUSE) && preset_ok(load_value)) begin
        {mt_nx, mo_nx, st_nx, so_nx} = load_value;
      end else begin
        err_nx = 1'b1;
      end
    end else if (stop) begin
      if (state == S_RUN) state_nx = S_PAUSE;
    end else if (start) begin
      if (state == S_IDLE || state == S_PAUSE) state_nx = S_RUN;
    end else if (tick && state == S_RUN) begin
      if (so != 4'd9) begin
        so_nx = so + 4'd1;
      end else if (st != 4'd5) begin
        so_nx = 4'd0;
        st_nx = st + 4'd1;
      end else if (mo != 4'd9) begin
        so_nx    = 4'd0;
        st_nx    = 4'd0;
        mo_nx    = mo + 4'd1;
        carry_nx = 1'b1;
      end else if (mt != MAX_MT_D) begin
        so_nx    = 4'd0;
        st_nx    = 4'd0;
        mo_nx    = 4'd0;
        mt_nx    = mt + 4'd1;
        carry_nx = 1'b1;
      end else begin
        // The count is already at its top value. Hold the digits and do not
        // report a minute carry, because no rollover happens.
        state_nx = S_FULL;
      end
    end
  end

  // Register stage: state, digits and flags all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      so        <= 4'd0;
      st        <= 4'd0;
      mo        <= 4'd0;
      mt        <= 4'd0;
      running   <= 1'b0;
      full      <= 1'b0;
      min_carry <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      so        <= so_nx;
      st        <= st_nx;
      mo        <= mo_nx;
      mt        <= mt_nx;
      running   <= (state_nx == S_RUN);
      full      <= (state_nx == S_FULL);
      min_carry <= carry_nx;
      load_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_elapsed_timer.sv
// Directed testbench for elapsed_timer (MAX_MT = 9). It compares the digits and
// flags against hand-computed values after each clock edge.
module tb_elapsed_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, stop, clear, load;
  logic [15:0] load_value;
  logic [3:0]  so, st, mo, mt;
  logic        running, full, min_carry, load_err;
  logic [15:0] disp;

  int n_checks = 0;
  int n_errors = 0;
  int carries;

  elapsed_timer #(.MAX_MT(9)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_value(load_value),
    .so(so), .st(st), .mo(mo), .mt(mt),
    .running(running), .full(full), .min_carry(min_carry), .load_err(load_err)
  );

  assign disp = {mt, mo, st, so};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one clock with the currently set strobes, sample 1 ns after the edge,
  // then release the strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
  endtask

  task automatic ticks(input int n, output int nc);
    nc = 0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      if (min_carry) nc++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    cyc();
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    load = 1'b0; load_value = 16'h0000;

    // Reset while other inputs are active.
    tick = 1'b1; start = 1'b1; load = 1'b1; load_value = 16'h1234;
    cyc();
    tick = 1'b1; start = 1'b1;
    cyc();
    check("rst_digits", disp, 16'h0000);
    check("rst_flags", {running, full, min_carry, load_err}, 4'b0000);
    rst = 1'b1;

    // 61 ticks from zero should give 01:01 with exactly one minute carry.
    start = 1'b1; cyc();
    check("start_running", running, 1'b1);
    ticks(61, carries);
    check("t61_digits", disp, 16'h0101);
    check("t61_carries", carries, 1);

    // Load in idle, then one tick rolls 09:59 over to 10:00.
    clear = 1'b1; cyc();
    check("clear_idle", {disp, running}, {16'h0000, 1'b0});
    do_load(16'h0959);
    check("load_idle", {disp, load_err, running}, {16'h0959, 1'b0, 1'b0});
    start = 1'b1; cyc();
    tick = 1'b1; cyc();
    check("roll_1000", disp, 16'h1000);
    check("roll_carry", min_carry, 1'b1);
    cyc();
    check("carry_onecyc", min_carry, 1'b0);

    // Saturate at 99:59.
    clear = 1'b1; cyc();
    do_load(16'h9958);
    start = 1'b1; cyc();
    tick = 1'b1; cyc();
    check("sat_t1", {disp, full, running}, {16'h9959, 1'b0, 1'b1});
    tick = 1'b1; cyc();
    check("sat_t2", {disp, full, running, min_carry}, {16'h9959, 1'b1, 1'b0, 1'b0});
    tick = 1'b1; cyc();
    check("sat_t3", {disp, full, running}, {16'h9959, 1'b1, 1'b0});
    start = 1'b1; cyc();
    check("full_start", {full, running}, 2'b10);
    stop = 1'b1; cyc();
    check("full_stop", {full, running}, 2'b10);
    do_load(16'h0000);
    check("full_load", {disp, load_err, full}, {16'h9959, 1'b1, 1'b1});

    // Pause holds the count, and resume continues from it.
    clear = 1'b1; cyc();
    check("clear_full", {disp, full, running}, {16'h0000, 1'b0, 1'b0});
    start = 1'b1; cyc();
    ticks(5, carries);
    check("run_0005", disp, 16'h0005);
    stop = 1'b1; cyc();
    check("pause_flag", running, 1'b0);
    ticks(4, carries);
    check("pause_hold", disp, 16'h0005);
    start = 1'b1; cyc();
    check("resume_flag", running, 1'b1);
    tick = 1'b1; cyc();
    check("resume_0006", disp, 16'h0006);

    // A tick in the same cycle as start or stop is ignored.
    tick = 1'b1; start = 1'b1; cyc();
    check("tick_start", {disp, running}, {16'h0006, 1'b1});
    tick = 1'b1; stop = 1'b1; cyc();
    check("tick_stop", {disp, running}, {16'h0006, 1'b0});

    // Rejected loads.
    clear = 1'b1; cyc();
    do_load(16'h0060);
    check("bad_st", {disp, load_err}, {16'h0000, 1'b1});
    cyc();
    check("err_onecyc", load_err, 1'b0);
    do_load(16'hA000);
    check("bad_mt", {disp, load_err}, {16'h0000, 1'b1});
    start = 1'b1; cyc();
    tick = 1'b1; cyc();
    do_load(16'h1234);
    check("load_run", {disp, load_err, running}, {16'h0001, 1'b1, 1'b1});
    tick = 1'b1; cyc();
    check("run_cont", disp, 16'h0002);

    // Clear beats tick at 12:34.
    clear = 1'b1; cyc();
    do_load(16'h1234);
    start = 1'b1; cyc();
    clear = 1'b1; tick = 1'b1; cyc();
    check("clear_tick", {disp, running}, {16'h0000, 1'b0});
    tick = 1'b1; cyc();
    check("idle_tick", disp, 16'h0000);

    // Reset during a run, on the cycle that would raise min_carry.
    do_load(16'h0059);
    start = 1'b1; cyc();
    rst = 1'b0; tick = 1'b1; cyc();
    check("rst_run", {disp, running, full, min_carry, load_err}, {16'h0000, 4'b0000});
    rst = 1'b1;
    tick = 1'b1; cyc();
    check("post_rst", {disp, running, min_carry}, {16'h0000, 2'b00});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
